// File: rtl/demux1_4_buf_if.sv
// Handshake bundle for the 1-to-4 buffered demux: one producer stream in,
// four consumer channels out, plus per-channel delivery counters.
interface demux1_4_buf_if #(
  parameter int SIZE = 64
);
  logic [1:0]      sel;
  logic [SIZE-1:0] data_i;
  logic            valid_i;
  logic            ready_o;
  logic [SIZE-1:0] data_o0, data_o1, data_o2, data_o3;
  logic [3:0]      valid_o;
  logic [3:0]      ready_i;
  logic [7:0]      cnt_o0, cnt_o1, cnt_o2, cnt_o3;
  logic            busy_o;

  modport master (
    output sel, data_i, valid_i, ready_i,
    input  ready_o, data_o0, data_o1, data_o2, data_o3, valid_o,
           cnt_o0, cnt_o1, cnt_o2, cnt_o3, busy_o
  );

  modport slave (
    input  sel, data_i, valid_i, ready_i,
    output ready_o, data_o0, data_o1, data_o2, data_o3, valid_o,
           cnt_o0, cnt_o1, cnt_o2, cnt_o3, busy_o
  );
endinterface

// File: rtl/demux1_4_buf.sv
// Registered 1-to-4 demux: sel steers each accepted word into a single-entry
// holding buffer per channel; channels drain independently.
module demux1_4_buf #(
  parameter int SIZE = 64
) (
  input logic           clock,
  input logic           reset,
  demux1_4_buf_if.slave bus
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][SIZE-1:0] data_q;
  logic [NUM_LANES-1:0][7:0]      cnt_q;
  logic [NUM_LANES-1:0]           valid_q;
  logic [NUM_LANES-1:0]           load;
  logic [NUM_LANES-1:0]           deliver;
  logic                           rdy;
  logic                           accept;

  // Only the addressed channel can stall the producer; no valid_i in this path.
  assign rdy    = ~valid_q[bus.sel] | bus.ready_i[bus.sel];
  assign accept = bus.valid_i & rdy;

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      assign load[k]    = accept & (bus.sel == 2'(k));
      assign deliver[k] = valid_q[k] & bus.ready_i[k];

      // A load in the same cycle as a delivery replaces the leaving word,
      // so the flag stays set.
      always_ff @(posedge clock) begin
        if (reset) begin
          data_q[k]  <= '0;
          valid_q[k] <= 1'b0;
          cnt_q[k]   <= '0;
        end else begin
          if (load[k]) begin
            data_q[k]  <= bus.data_i;
            valid_q[k] <= 1'b1;
          end else if (deliver[k]) begin
            valid_q[k] <= 1'b0;
          end
          if (deliver[k])
            cnt_q[k] <= cnt_q[k] + 8'd1;
        end
      end
    end
  endgenerate

  assign bus.ready_o = rdy;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = |valid_q;
  assign bus.data_o0 = data_q[0];
  assign bus.data_o1 = data_q[1];
  assign bus.data_o2 = data_q[2];
  assign bus.data_o3 = data_q[3];
  assign bus.cnt_o0  = cnt_q[0];
  assign bus.cnt_o1  = cnt_q[1];
  assign bus.cnt_o2  = cnt_q[2];
  assign bus.cnt_o3  = cnt_q[3];
endmodule

// File: tb/tb_demux1_4_buf.sv
// Directed bench for demux1_4_buf: per-channel scoreboard queues filled on
// accept, drained and compared on delivery; registered outputs checked each cycle.
module tb_demux1_4_buf;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  demux1_4_buf_if #(.SIZE(64)) bus();
  demux1_4_buf #(.SIZE(64)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  typedef logic [63:0] q_t[$];
  q_t          sb[4];
  logic [63:0] mdata[4];
  logic [7:0]  mcnt[4];
  logic [3:0]  mvalid;
  int          nassert = 0;
  int          nfail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dout(input int k);
    case (k)
      0: return bus.data_o0;
      1: return bus.data_o1;
      2: return bus.data_o2;
      default: return bus.data_o3;
    endcase
  endfunction

  function automatic logic [7:0] cout(input int k);
    case (k)
      0: return bus.cnt_o0;
      1: return bus.cnt_o1;
      2: return bus.cnt_o2;
      default: return bus.cnt_o3;
    endcase
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ":valid_o"}, 64'(bus.valid_o), 64'(mvalid));
    chk({tag, ":busy_o"}, 64'(bus.busy_o), 64'(|mvalid));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s:data_o%0d", tag, k), dout(k), mdata[k]);
      chk($sformatf("%s:cnt_o%0d", tag, k), 64'(cout(k)), 64'(mcnt[k]));
    end
  endtask

  // One cycle: drive at negedge, check ready_o and delivered words before the
  // edge, update the model at the edge, then check registered outputs.
  task automatic step(input logic [1:0] s, input logic [63:0] d, input logic v,
                      input logic [3:0] r, input string tag);
    logic exp_rdy;
    @(negedge clock);
    bus.sel = s; bus.data_i = d; bus.valid_i = v; bus.ready_i = r;
    #1;
    exp_rdy = ~mvalid[s] | r[s];
    chk({tag, ":ready_o"}, 64'(bus.ready_o), 64'(exp_rdy));
    for (int k = 0; k < 4; k++) begin
      if (mvalid[k] && r[k]) begin
        if (sb[k].size() == 0) begin
          chk($sformatf("%s:sb_empty%0d", tag, k), 64'd1, 64'd0);
        end else begin
          chk($sformatf("%s:deliver%0d", tag, k), dout(k), sb[k].pop_front());
        end
        mcnt[k]   = mcnt[k] + 8'd1;
        mvalid[k] = 1'b0;
      end
    end
    if (v && exp_rdy) begin
      sb[s].push_back(d);
      mdata[s]  = d;
      mvalid[s] = 1'b1;
    end
    @(posedge clock);
    #1;
    check_outs(tag);
  endtask

  task automatic do_reset(input logic v, input logic [1:0] s, input logic [63:0] d, input string tag);
    @(negedge clock);
    reset = 1'b1;
    bus.sel = s; bus.data_i = d; bus.valid_i = v; bus.ready_i = 4'hF;
    @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++) begin
      sb[k].delete();
      mdata[k] = '0;
      mcnt[k]  = '0;
    end
    mvalid = '0;
    check_outs(tag);
    @(negedge clock);
    reset = 1'b0;
    bus.valid_i = 1'b0; bus.ready_i = '0;
  endtask

  initial begin
    bus.sel = '0; bus.data_i = '0; bus.valid_i = 1'b0; bus.ready_i = '0;
    for (int k = 0; k < 4; k++) begin mdata[k] = '0; mcnt[k] = '0; end
    mvalid = '0;

    do_reset(1'b0, 2'd0, 64'd0, "reset");
    step(2'd0, 64'd0, 1'b0, 4'hF, "idle0");
    step(2'd1, 64'hFFFF, 1'b0, 4'hF, "idle1");

    step(2'd2, 64'hA5, 1'b1, 4'h0, "route_load");
    chk("route_data_o2", bus.data_o2, 64'hA5);
    step(2'd2, 64'd0, 1'b0, 4'h0, "route_stall");
    step(2'd2, 64'd0, 1'b0, 4'b0100, "route_drain");
    chk("route_cnt_o2", 64'(bus.cnt_o2), 64'd1);

    step(2'd0, 64'h111, 1'b1, 4'h0, "iso0");
    step(2'd1, 64'h222, 1'b1, 4'h0, "iso1");
    step(2'd2, 64'h333, 1'b1, 4'h0, "iso2");
    step(2'd3, 64'h444, 1'b1, 4'h0, "iso3");
    chk("iso_valid_all", 64'(bus.valid_o), 64'hF);
    step(2'd0, 64'h999, 1'b1, 4'h0, "iso_blocked");
    chk("iso_data_o0", bus.data_o0, 64'h111);
    step(2'd0, 64'd0, 1'b0, 4'hF, "iso_drain");

    for (int i = 0; i < 300; i++)
      step(2'd3, 64'(i), 1'b1, 4'b1000, "stream");
    step(2'd3, 64'd0, 1'b0, 4'b1000, "stream_drain");
    chk("stream_cnt_o3", 64'(bus.cnt_o3), 64'd45);

    step(2'd1, 64'd11, 1'b1, 4'h0, "sim_load");
    step(2'd1, 64'd22, 1'b1, 4'b0010, "sim_swap");
    chk("sim_data_o1", bus.data_o1, 64'd22);
    chk("sim_cnt_o1", 64'(bus.cnt_o1), 64'd2);

    step(2'd0, 64'hAA, 1'b1, 4'h0, "mid0");
    step(2'd3, 64'hBB, 1'b1, 4'h0, "mid3");
    do_reset(1'b1, 2'd2, 64'hCC, "mid_reset");
    step(2'd0, 64'd0, 1'b0, 4'h0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
